regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter in front of the two write ports of the register file. Accepts register write requests from `NREQ` producers (ALU, load unit, multiplier, …) over valid/ready handshakes. Grants at most two per cycle under a rotating priority, never two to the same register, and drives `write0/waddr0/in0` and `write1/waddr1/in1` from output registers. Also exports a pending-write mask so the issue logic can bypass or stall on registers about to be written.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `WIDTH_SEG`, `WIDTH_WORD`: taken from the shared constants header, not parameters. Register count is 2**`WIDTH_SEG`.
- `clk` in 1: single clock, all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `NREQ`: request i holds a write.
- `req_addr` in `NREQ`*`WIDTH_SEG`: target register of request i, slice i.
- `req_data` in `NREQ`*`WIDTH_WORD`: write data of request i, slice i.
- `req_ready` out `NREQ`: request i granted this cycle. Transfer occurs when valid && ready.
- `hold` in 1: when high, no grants this cycle.
- `write0`, `write1` out 1: write strobes to register file ports 0/1.
- `waddr0`, `waddr1` out `WIDTH_SEG`: write addresses.
- `in0`, `in1` out `WIDTH_WORD`: write data.
- `pending` out 2**`WIDTH_SEG`: bit r set when a registered write to r is on the outputs this cycle.

## Operation
- Requesters hold `req_valid`, `req_addr` and `req_data` stable until granted. Valid is never withdrawn before a grant.
- Rotating pointer `rr` (log2 `NREQ` bits) marks the highest-priority requester. Scan order is rr, rr+1, …, wrapping mod `NREQ`.
- **Slot 0:** the first valid requester in scan order is granted and placed on port 0.
- **Slot 1:** the next valid requester whose `req_addr` differs from slot 0's is granted and placed on port 1.
  - A requester with the same address as slot 0 is skipped and stays pending.
  - Same-address requests are therefore serialized in priority order. The later one writes in a later cycle and wins.
- `req_ready` is combinational from `req_valid`, `req_addr`, `rr` and `hold`. At most two bits are set, and only for valid requesters.
- **Pointer update after a grant:** `rr` moves to (index of last granted requester + 1) mod `NREQ`. With no grant, `rr` is unchanged.
- When `hold` is high or `rst` is high, `req_ready` is all zero.
- **Output registers:** each cycle they load the granted address/data with the strobe set, or clear the strobe when the slot is empty. Addr/data keep their last value when the strobe is 0.
- Port 0 always carries the higher-priority grant. Port 1 is never strobed without port 0.
- `pending` is the decoded OR of (`write0`, `waddr0`) and (`write1`, `waddr1`). It is derived from the output registers only.
- **Reset values:** `write0`=`write1`=0, `waddr*`=0, `in*`=0, `rr`=0, `pending`=0, `req_ready`=0.

## Timing
- Grant in cycle t: strobe, address and data appear on the write ports in cycle t+1. The register file captures them at the end of t+1.
- Write-back latency from handshake to register update is 2 edges. Throughput is 2 writes/cycle.
- Back-to-back grants to one requester are allowed on consecutive cycles.
- **Reset mid-operation:** a request granted in the cycle `rst` is high is not accepted, since ready is forced to 0. Writes already registered are dropped, because the strobes clear on the same edge.
- **Deassertion of `hold`:** grants resume in the same cycle with the preserved `rr`. The output strobes clear in the cycle after `hold` rises.
- **Starvation bound:** a continuously valid requester is granted within `NREQ` cycles.

## Structure
- `WIDTH_SEG` and `WIDTH_WORD` stay in the shared constants header. Add `NREQ_WB` (default 4) there for the top-level instance.
- One sub-module, `rr_pick2`, is natural.
  - Purely combinational.
  - Inputs: valid vector, packed addresses, pointer.
  - Outputs: two one-hot grants plus found flags.
- The top level holds the pointer, output registers and pending decoder.

## Test plan
- **Reset, then idle:** all outputs 0. Assert `req_valid`=4'b0001, addr 3, data 0x11 → `req_ready`=0001. Next cycle `write0`=1, `waddr0`=3, `in0`=0x11, `write1`=0, `pending`=bit 3.
- **Two distinct, rr=0:** requesters 1 (addr 2) and 2 (addr 5) valid → both ready. Port 0 carries addr 2, port 1 carries addr 5. `rr` becomes 3.
- **Same-address conflict:** requesters 0 and 1 both target addr 7, data 0xA/0xB. Cycle 1 grants only 0 (port 0: 7/0xA). Cycle 2 grants 1 (port 0: 7/0xB). The register file ends with 0xB.
- **Fairness:** all four requesters continuously valid with distinct addresses → grant pairs {0,1}, {2,3}, {0,1}, … Each requester is granted every 2 cycles.
- **Hold:** `hold`=1 for 3 cycles with requests pending → `req_ready`=0 and the strobes clear after one cycle. After release, grants resume from the preserved `rr`.
- **Reset mid-stream:** assert `rst` while writes are on the ports → next cycle strobes 0, `pending`=0, `rr`=0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back path: word/segment widths,
// default requester count and the registered write-port record.
package regfile_wb_arbiter_pkg;

  localparam int WIDTH_SEG  = 5;
  localparam int WIDTH_WORD = 32;
  localparam int NREQ_WB    = 4;
  localparam int NREG       = 2 ** WIDTH_SEG;

  typedef struct packed {
    logic                  write;
    logic [WIDTH_SEG-1:0]  addr;
    logic [WIDTH_WORD-1:0] data;
  } wb_port_t;

  // Width of a pointer into n requesters; never zero so a 1-requester build still elaborates.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Request bus from the write-back producers into the arbiter.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_WB
);

  // Handshake: requester i raises req_valid[i] with req_addr/req_data slice i and holds
  // all three stable until it sees req_ready[i]; the write transfers on the edge where
  // valid && ready, and valid is never withdrawn before that. hold suppresses all grants.
  logic [NREQ-1:0]            req_valid;
  logic [NREQ*WIDTH_SEG-1:0]  req_addr;
  logic [NREQ*WIDTH_WORD-1:0] req_data;
  logic [NREQ-1:0]            req_ready;
  logic                       hold;

  modport master (
    output req_valid, req_addr, req_data, hold,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_addr, req_data, hold,
    output req_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_pick2.sv
// Combinational two-slot round-robin picker: slot 0 is the first valid requester from rr,
// slot 1 the next valid one targeting a different register.
module rr_pick2
  import regfile_wb_arbiter_pkg::*;
#(
  parameter  int NREQ = NREQ_WB,
  localparam int RRW  = ptr_w(NREQ)
) (
  input  logic [NREQ-1:0]           valid,
  input  logic [NREQ*WIDTH_SEG-1:0] addr,
  input  logic [RRW-1:0]            rr,
  output logic [NREQ-1:0]           gnt0,
  output logic [NREQ-1:0]           gnt1,
  output logic                      found0,
  output logic                      found1
);

  logic [WIDTH_SEG-1:0] addr0;
  logic [RRW-1:0]       j;

  always_comb begin
    gnt0   = '0;
    gnt1   = '0;
    found0 = 1'b0;
    found1 = 1'b0;
    addr0  = '0;
    j      = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = RRW'((int'(rr) + k) % NREQ);
      if (valid[j]) begin
        if (!found0) begin
          found0  = 1'b1;
          gnt0[j] = 1'b1;
          addr0   = addr[j*WIDTH_SEG +: WIDTH_SEG];
        end else if (!found1 && (addr[j*WIDTH_SEG +: WIDTH_SEG] != addr0)) begin
          // Same-register requests are left pending so they serialize in priority order.
          found1  = 1'b1;
          gnt1[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: grants up to two producer writes per cycle onto the two register
// file write ports through output registers, and exports the pending-write mask.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter  int NREQ = NREQ_WB,
  localparam int RRW  = ptr_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   bus,
  output logic                  write0,
  output logic [WIDTH_SEG-1:0]  waddr0,
  output logic [WIDTH_WORD-1:0] in0,
  output logic                  write1,
  output logic [WIDTH_SEG-1:0]  waddr1,
  output logic [WIDTH_WORD-1:0] in1,
  output logic [NREG-1:0]       pending,
  output logic [RRW-1:0]        dbg_rr
);

  logic [RRW-1:0]        rr;
  logic [RRW-1:0]        rr_n;
  logic [NREQ-1:0]       gnt0;
  logic [NREQ-1:0]       gnt1;
  logic                  found0;
  logic                  found1;
  logic                  grant_en;
  logic                  take0;
  logic                  take1;
  logic [RRW-1:0]        idx0;
  logic [RRW-1:0]        idx1;
  logic [RRW-1:0]        last_idx;
  logic [WIDTH_SEG-1:0]  sel_addr0;
  logic [WIDTH_SEG-1:0]  sel_addr1;
  logic [WIDTH_WORD-1:0] sel_data0;
  logic [WIDTH_WORD-1:0] sel_data1;
  wb_port_t              port0_q;
  wb_port_t              port1_q;

  rr_pick2 #(
    .NREQ (NREQ)
  ) u_pick (
    .valid  (bus.req_valid),
    .addr   (bus.req_addr),
    .rr     (rr),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .found0 (found0),
    .found1 (found1)
  );

  assign grant_en      = !bus.hold && !rst;
  assign take0         = grant_en && found0;
  assign take1         = grant_en && found1;
  assign bus.req_ready = grant_en ? (gnt0 | gnt1) : '0;

  // One-hot grants back to indices and the matching address/data slices.
  always_comb begin
    idx0      = '0;
    idx1      = '0;
    sel_addr0 = '0;
    sel_addr1 = '0;
    sel_data0 = '0;
    sel_data1 = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt0[k]) begin
        idx0      = RRW'(k);
        sel_addr0 = bus.req_addr[k*WIDTH_SEG +: WIDTH_SEG];
        sel_data0 = bus.req_data[k*WIDTH_WORD +: WIDTH_WORD];
      end
      if (gnt1[k]) begin
        idx1      = RRW'(k);
        sel_addr1 = bus.req_addr[k*WIDTH_SEG +: WIDTH_SEG];
        sel_data1 = bus.req_data[k*WIDTH_WORD +: WIDTH_WORD];
      end
    end
  end

  // Slot 1 always lies later in scan order, so it is the last granted when present.
  always_comb begin
    last_idx = found1 ? idx1 : idx0;
    if (int'(last_idx) == NREQ - 1) rr_n = '0;
    else                            rr_n = last_idx + RRW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr      <= '0;
      port0_q <= '0;
      port1_q <= '0;
    end else begin
      if (take0) rr <= rr_n;
      port0_q.write <= take0;
      port1_q.write <= take1;
      if (take0) begin
        port0_q.addr <= sel_addr0;
        port0_q.data <= sel_data0;
      end
      if (take1) begin
        port1_q.addr <= sel_addr1;
        port1_q.data <= sel_data1;
      end
    end
  end

  always_comb begin
    pending = '0;
    if (port0_q.write) pending[port0_q.addr] = 1'b1;
    if (port1_q.write) pending[port1_q.addr] = 1'b1;
  end

  assign write0 = port0_q.write;
  assign waddr0 = port0_q.addr;
  assign in0    = port0_q.data;
  assign write1 = port1_q.write;
  assign waddr1 = port1_q.addr;
  assign in1    = port1_q.data;
  assign dbg_rr = rr;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic against a
// priority-list reference model, with a queue-based scoreboard on the write ports.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int WS   = WIDTH_SEG;
  localparam int WW   = WIDTH_WORD;
  localparam int RRW  = $clog2(NREQ);

  typedef struct packed {
    logic          w0;
    logic [WS-1:0] a0;
    logic [WW-1:0] d0;
    logic          w1;
    logic [WS-1:0] a1;
    logic [WW-1:0] d1;
    logic [RRW-1:0] rr;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NREQ(NREQ)) bus ();

  logic           write0, write1;
  logic [WS-1:0]  waddr0, waddr1;
  logic [WW-1:0]  in0, in1;
  logic [NREG-1:0] pending;
  logic [RRW-1:0] dbg_rr;

  regfile_wb_arbiter #(.NREQ(NREQ)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .write0  (write0),
    .waddr0  (waddr0),
    .in0     (in0),
    .write1  (write1),
    .waddr1  (waddr1),
    .in1     (in1),
    .pending (pending),
    .dbg_rr  (dbg_rr)
  );

  logic          tv_valid[NREQ];
  logic [WS-1:0] tv_addr[NREQ];
  logic [WW-1:0] tv_data[NREQ];
  logic          tv_hold;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]            = tv_valid[i];
      bus.req_addr[i*WS +: WS]    = tv_addr[i];
      bus.req_data[i*WW +: WW]    = tv_data[i];
    end
    bus.hold = tv_hold;
  end

  // ---------------- reference model state ----------------
  int            m_rr;
  logic [WS-1:0] m_a0, m_a1;
  logic [WW-1:0] m_d0, m_d1;
  logic [NREQ-1:0] granted;
  logic [WW-1:0] dut_rf[NREG];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic req(input int i, input logic [WS-1:0] a, input logic [WW-1:0] d);
    tv_valid[i] = 1'b1;
    tv_addr[i]  = a;
    tv_data[i]  = d;
  endtask

  // One cycle: model decides the grants from the settled inputs, checks req_ready,
  // queues the expected port contents, then retires the granted requests after the edge.
  task automatic step();
    int order[$];
    int g0, g1;
    exp_t e;
    logic [NREQ-1:0] er;
    @(negedge clk);
    g0 = -1;
    g1 = -1;
    er = '0;
    if (!rst && !tv_hold) begin
      for (int k = 0; k < NREQ; k++)
        if (tv_valid[(m_rr + k) % NREQ]) order.push_back((m_rr + k) % NREQ);
      if (order.size() > 0) g0 = order[0];
      for (int m = 1; m < order.size(); m++)
        if (g1 < 0 && tv_addr[order[m]] != tv_addr[g0]) g1 = order[m];
    end
    if (g0 >= 0) er[g0] = 1'b1;
    if (g1 >= 0) er[g1] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(er));
    e = '0;
    if (rst) begin
      m_rr = 0;
      m_a0 = '0; m_d0 = '0; m_a1 = '0; m_d1 = '0;
    end else begin
      if (g0 >= 0) begin m_a0 = tv_addr[g0]; m_d0 = tv_data[g0]; end
      if (g1 >= 0) begin m_a1 = tv_addr[g1]; m_d1 = tv_data[g1]; end
      if (g1 >= 0)      m_rr = (g1 + 1) % NREQ;
      else if (g0 >= 0) m_rr = (g0 + 1) % NREQ;
      e.w0 = (g0 >= 0);
      e.w1 = (g1 >= 0);
      e.a0 = m_a0; e.d0 = m_d0;
      e.a1 = m_a1; e.d1 = m_d1;
      e.rr = RRW'(m_rr);
    end
    exp_q.push_back(e);
    granted = er;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (granted[i]) tv_valid[i] = 1'b0;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) tv_valid[i] = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    clear_reqs();
    repeat (n) step();
    rst = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    exp_t e;
    logic [NREG-1:0] ep;
    for (int r = 0; r < NREG; r++) dut_rf[r] = '0;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        ep = '0;
        if (e.w0) ep[e.a0] = 1'b1;
        if (e.w1) ep[e.a1] = 1'b1;
        chk("write0",  64'(write0),  64'(e.w0));
        chk("waddr0",  64'(waddr0),  64'(e.a0));
        chk("in0",     64'(in0),     64'(e.d0));
        chk("write1",  64'(write1),  64'(e.w1));
        chk("waddr1",  64'(waddr1),  64'(e.a1));
        chk("in1",     64'(in1),     64'(e.d1));
        chk("pending", 64'(pending), 64'(ep));
        chk("rr",      64'(dbg_rr),  64'(e.rr));
        if (write0) dut_rf[waddr0] = in0;
        if (write1) dut_rf[waddr1] = in1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    tv_hold = 1'b0;
    m_rr = 0;
    m_a0 = '0; m_d0 = '0; m_a1 = '0; m_d1 = '0;
    granted = '0;
    for (int i = 0; i < NREQ; i++) begin
      tv_valid[i] = 1'b0;
      tv_addr[i]  = '0;
      tv_data[i]  = '0;
    end

    // reset, idle, single request
    do_reset(2);
    step();
    req(0, 5'd3, 32'h11);
    step();
    step();

    // two distinct addresses from rr=0
    do_reset(1);
    req(1, 5'd2, 32'h22);
    req(2, 5'd5, 32'h55);
    step();
    step();

    // same-address conflict serializes, later writer wins
    do_reset(1);
    req(0, 5'd7, 32'hA);
    req(1, 5'd7, 32'hB);
    step();
    step();
    step();
    chk("rf7_final", 64'(dut_rf[7]), 64'h B);

    // fairness: all four continuously valid with distinct addresses
    do_reset(1);
    for (int i = 0; i < NREQ; i++) req(i, WS'(10 + i), $urandom);
    repeat (8) begin
      step();
      for (int i = 0; i < NREQ; i++) if (granted[i]) req(i, WS'(10 + i), $urandom);
    end

    // hold for three cycles with requests pending, then resume
    tv_hold = 1'b1;
    repeat (3) step();
    tv_hold = 1'b0;
    repeat (3) begin
      step();
      for (int i = 0; i < NREQ; i++) if (granted[i]) req(i, WS'(10 + i), $urandom);
    end

    // reset while writes sit on the ports
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_reqs();
    step();
    step();

    // random traffic with address conflicts, holds and occasional resets
    repeat (400) begin
      for (int i = 0; i < NREQ; i++)
        if (!tv_valid[i] && $urandom_range(0, 1) == 1)
          req(i, WS'($urandom_range(0, 7)), $urandom);
      tv_hold = ($urandom_range(0, 9) == 0);
      rst     = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    tv_hold = 1'b0;
    clear_reqs();
    step();
    step();
    @(posedge clk);
    #3;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
